passenger_array_ctrl: RTL and testbench

- Parametrised successor of the elevator-sim people controller.
- Manages NUM_PEOPLE passenger slots across NUM_ELEV elevators and NUM_FLOORS floors. Each slot runs its own FSM: spawn, walk to a door, wait, ride, walk out.
- Adds per-elevator capacity limits, an active-passenger cap, hall/car request bitmaps and a delivered-passenger counter.
- Sits between the RNG/sim-control logic and the elevator controllers and display renderer.

---
 rtl/passenger_array_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_passenger_array_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/passenger_array_ctrl.sv
// Passenger slot array: per-slot spawn/walk/wait/ride/exit FSMs with capacity
// arbitration, hall/car request bitmaps and a delivered-trip counter.
module passenger_array_ctrl #(
   parameter int unsigned NUM_PEOPLE = 16,
   parameter int unsigned NUM_FLOORS = 6,
   parameter int unsigned NUM_ELEV   = 2,
   parameter int unsigned FW         = 3,
   parameter int unsigned EW         = 1,
   parameter int unsigned SCREEN_W   = 640,
   parameter int unsigned DOOR_X0    = 220,
   parameter int unsigned DOOR_PITCH = 40,
   parameter int unsigned CAPACITY   = 4,
   parameter int unsigned MAX_ACTIVE = 12
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       sim_state,
   input  logic                             tick,
   input  logic [1:0]                       speed,
   input  logic                             spawn_en,
   input  logic [31:0]                      rand_bits,
   input  logic [NUM_ELEV*FW-1:0]           elev_floor,
   input  logic [NUM_ELEV-1:0]              elev_door_open,
   output logic [3*NUM_PEOPLE-1:0]          p_state,
   output logic [10*NUM_PEOPLE-1:0]         p_xpos,
   output logic [FW*NUM_PEOPLE-1:0]         p_floor,
   output logic [EW*NUM_PEOPLE-1:0]         p_elev,
   output logic [NUM_PEOPLE-1:0]            active_mask,
   output logic [$clog2(NUM_PEOPLE+1)-1:0]  active_count,
   output logic [NUM_ELEV*NUM_FLOORS-1:0]   floor_req,
   output logic [NUM_ELEV*NUM_FLOORS-1:0]   car_req,
   output logic [15:0]                      delivered_count
);
   localparam int unsigned AW = $clog2(NUM_PEOPLE + 1);
   localparam int unsigned IW = (NUM_PEOPLE > 1) ? $clog2(NUM_PEOPLE) : 1;
   localparam int unsigned XW = 10;
   localparam logic [1:0] SIM_START = 2'd0, SIM_RUN = 2'd1, SIM_ENDING = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_SPAWN = 3'd1, S_WALK_IN = 3'd2,
      S_WAIT = 3'd3, S_RIDE = 3'd4, S_WALK_OUT = 3'd5
   } state_t;

   state_t          r_state [NUM_PEOPLE];
   logic [XW-1:0]   r_x     [NUM_PEOPLE];
   logic [XW-1:0]   r_xexit [NUM_PEOPLE];
   logic [FW-1:0]   r_floor [NUM_PEOPLE];
   logic [FW-1:0]   r_dest  [NUM_PEOPLE];
   logic [EW-1:0]   r_elev  [NUM_PEOPLE];
   logic [AW-1:0]   r_active_count;
   logic [15:0]     r_delivered;

   logic [XW-1:0]   w_x_next [NUM_PEOPLE];
   logic [AW-1:0]   w_riders [NUM_ELEV];
   logic [NUM_PEOPLE-1:0] w_arrive, w_board, w_exit, w_finish, w_active;
   logic [NUM_ELEV-1:0]   w_taken;
   logic [AW-1:0]   w_active_cnt;
   logic [IW-1:0]   w_spawn_idx;
   logic            w_idle_found, w_fin_taken, w_walk_en, w_spawn_ok;
   logic [NUM_ELEV*NUM_FLOORS-1:0] w_floor_req, w_car_req;

   logic [EW-1:0]   w_r_e;
   logic [FW-1:0]   w_r_start, w_r_dest, w_r_dest_adj;
   logic [XW-1:0]   w_r_x0, w_r_xexit;
   logic            w_unused_rand;

   // Returns {reached, next_x}; clamps to target before stepping so no wrap is possible
   function automatic logic [XW:0] f_walk(input logic [XW-1:0] x, input logic [XW-1:0] t,
                                          input logic [1:0] spd);
      logic [XW-1:0] d;
      d = (x >= t) ? x - t : t - x;
      if (d <= {8'd0, spd})  return {1'b1, t};
      else if (x > t)        return {1'b0, x - {8'd0, spd}};
      else                   return {1'b0, x + {8'd0, spd}};
   endfunction

   assign w_r_e         = rand_bits[EW-1:0];
   assign w_r_start     = rand_bits[8 +: FW];
   assign w_r_dest      = rand_bits[12 +: FW];
   assign w_r_x0        = rand_bits[16 +: XW];
   assign w_r_xexit     = {4'd0, rand_bits[26 +: 6]} * 10'd10;
   assign w_r_dest_adj  = (w_r_dest != w_r_start) ? w_r_dest :
                          (32'(w_r_start) == NUM_FLOORS - 1) ? FW'(0) : FW'(w_r_start + 1'b1);
   assign w_unused_rand = ^rand_bits;
   assign w_walk_en     = tick && (speed != 2'd0);

   // Per-slot arbitration, walking and request bitmaps from registered state
   always_comb begin
      logic [XW:0]   v_walk;
      logic [XW-1:0] v_tgt;
      int unsigned   v_e;
      w_arrive = '0; w_board = '0; w_exit = '0; w_finish = '0; w_active = '0;
      w_taken = '0; w_fin_taken = 1'b0; w_idle_found = 1'b0; w_spawn_idx = '0;
      w_floor_req = '0; w_car_req = '0; w_active_cnt = '0;
      v_walk = '0; v_tgt = '0; v_e = 0;
      for (int e = 0; e < NUM_ELEV; e++) w_riders[e] = '0;
      for (int i = 0; i < NUM_PEOPLE; i++) begin
         w_x_next[i]  = r_x[i];
         w_active[i]  = (r_state[i] != S_IDLE);
         w_active_cnt = w_active_cnt + AW'(w_active[i]);
         if (r_state[i] == S_RIDE) w_riders[r_elev[i]] = AW'(w_riders[r_elev[i]] + 1'b1);
      end
      for (int i = 0; i < NUM_PEOPLE; i++) begin
         v_e = 32'(r_elev[i]);
         case (r_state[i])
            S_IDLE: if (!w_idle_found) begin
               w_idle_found = 1'b1;
               w_spawn_idx  = IW'(i);
            end
            S_WALK_IN: begin
               v_tgt  = XW'(DOOR_X0 + v_e * DOOR_PITCH);
               v_walk = f_walk(r_x[i], v_tgt, speed);
               if (w_walk_en) begin
                  w_x_next[i] = v_walk[XW-1:0];
                  w_arrive[i] = v_walk[XW];
               end
            end
            S_WAIT: begin
               w_floor_req[v_e*NUM_FLOORS + 32'(r_floor[i])] = 1'b1;
               if (!w_taken[v_e] && elev_door_open[v_e] &&
                   elev_floor[v_e*FW +: FW] == r_floor[i] &&
                   32'(w_riders[v_e]) < CAPACITY) begin
                  w_board[i]   = 1'b1;
                  w_taken[v_e] = 1'b1;
               end
            end
            S_RIDE: begin
               w_car_req[v_e*NUM_FLOORS + 32'(r_dest[i])] = 1'b1;
               w_exit[i] = elev_door_open[v_e] && (elev_floor[v_e*FW +: FW] == r_dest[i]);
            end
            S_WALK_OUT: begin
               // Slots that lost the finish arbitration park on the target and retry
               v_walk = f_walk(r_x[i], r_xexit[i], speed);
               if (w_walk_en) w_x_next[i] = v_walk[XW-1:0];
               if (((w_walk_en && v_walk[XW]) || r_x[i] == r_xexit[i]) && !w_fin_taken) begin
                  w_finish[i] = 1'b1;
                  w_fin_taken = 1'b1;
               end
            end
            default: ;
         endcase
      end
      w_spawn_ok = spawn_en && (32'(r_active_count) < MAX_ACTIVE) && w_idle_found &&
                   (32'(w_r_e) < NUM_ELEV) && (32'(w_r_start) < NUM_FLOORS) &&
                   (32'(w_r_dest) < NUM_FLOORS) && (32'(w_r_x0) < SCREEN_W) &&
                   (32'(w_r_xexit) < SCREEN_W);
   end

   always_ff @(posedge clk) begin
      if (rst || sim_state == SIM_START || sim_state == SIM_ENDING) begin
         for (int i = 0; i < NUM_PEOPLE; i++) begin
            r_state[i] <= S_IDLE;
            r_x[i]     <= '0;
            r_xexit[i] <= '0;
            r_floor[i] <= '0;
            r_dest[i]  <= '0;
            r_elev[i]  <= '0;
         end
         r_active_count <= '0;
         if (rst || sim_state == SIM_START) r_delivered <= '0;
      end else if (sim_state == SIM_RUN) begin
         r_active_count <= w_active_cnt;
         if ((|w_finish) && r_delivered != 16'hFFFF) r_delivered <= r_delivered + 16'd1;
         for (int i = 0; i < NUM_PEOPLE; i++) begin
            case (r_state[i])
               S_IDLE: if (w_spawn_ok && w_spawn_idx == IW'(i)) begin
                  r_state[i] <= S_SPAWN;
                  r_x[i]     <= w_r_x0;
                  r_xexit[i] <= w_r_xexit;
                  r_floor[i] <= w_r_start;
                  r_dest[i]  <= w_r_dest_adj;
                  r_elev[i]  <= w_r_e;
               end
               S_SPAWN: r_state[i] <= S_WALK_IN;
               S_WALK_IN: begin
                  r_x[i] <= w_x_next[i];
                  if (w_arrive[i]) r_state[i] <= S_WAIT;
               end
               S_WAIT: if (w_board[i]) r_state[i] <= S_RIDE;
               S_RIDE: begin
                  r_floor[i] <= elev_floor[32'(r_elev[i])*FW +: FW];
                  if (w_exit[i]) r_state[i] <= S_WALK_OUT;
               end
               S_WALK_OUT: begin
                  r_x[i] <= w_x_next[i];
                  if (w_finish[i]) r_state[i] <= S_IDLE;
               end
               default: r_state[i] <= S_IDLE;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_PEOPLE; g++) begin : g_flat
      assign p_state[g*3 +: 3]   = r_state[g];
      assign p_xpos[g*XW +: XW]  = r_x[g];
      assign p_floor[g*FW +: FW] = r_floor[g];
      assign p_elev[g*EW +: EW]  = r_elev[g];
   end

   assign active_mask     = w_active;
   assign active_count    = r_active_count;
   assign floor_req       = w_floor_req;
   assign car_req         = w_car_req;
   assign delivered_count = r_delivered;
endmodule

// File: tb/tb_passenger_array_ctrl.sv
// Scoreboard bench for passenger_array_ctrl: spawn, walk, board, capacity,
// rejection, pause and ending behaviour with default parameters.
module tb_passenger_array_ctrl;
   logic        clk = 1'b0;
   logic        rst, tick, spawn_en;
   logic [1:0]  sim_state, speed;
   logic [31:0] rand_bits;
   logic [5:0]  elev_floor;
   logic [1:0]  elev_door_open;
   logic [47:0]  p_state, p_floor;
   logic [159:0] p_xpos;
   logic [15:0]  p_elev, active_mask, delivered_count;
   logic [4:0]   active_count;
   logic [11:0]  floor_req, car_req;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { string tag; logic [255:0] val; } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   passenger_array_ctrl dut (
      .clk(clk), .rst(rst), .sim_state(sim_state), .tick(tick), .speed(speed),
      .spawn_en(spawn_en), .rand_bits(rand_bits), .elev_floor(elev_floor),
      .elev_door_open(elev_door_open), .p_state(p_state), .p_xpos(p_xpos),
      .p_floor(p_floor), .p_elev(p_elev), .active_mask(active_mask),
      .active_count(active_count), .floor_req(floor_req), .car_req(car_req),
      .delivered_count(delivered_count)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [255:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [255:0] got);
      exp_t e;
      if (sb_q.size() == 0) check_eq("sb_depth", 256'(sb_q.size()), 256'd1);
      else begin
         e = sb_q.pop_front();
         check_eq(e.tag, got, e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
   endtask

   function automatic logic [2:0] st(input int i);
      return p_state[i*3 +: 3];
   endfunction

   function automatic logic [31:0] mk_rand(input int e, input int s, input int d,
                                           input int x0, input int xq);
      return {6'(xq), 10'(x0), 1'b0, 3'(d), 1'b0, 3'(s), 7'd0, 1'(e)};
   endfunction

   initial begin
      logic [47:0]  exp_st;
      logic [159:0] exp_x;
      int n;
      rst = 1'b1; sim_state = 2'd0; tick = 1'b0; speed = 2'd3; spawn_en = 1'b0;
      rand_bits = '0; elev_floor = '0; elev_door_open = '0;
      step(); step();
      rst = 1'b0;
      step();
      check_eq("rst_state", 256'(p_state), 256'd0);
      check_eq("rst_floor_req", 256'(floor_req), 256'd0);
      check_eq("rst_car_req", 256'(car_req), 256'd0);
      check_eq("rst_delivered", 256'(delivered_count), 256'd0);
      check_eq("rst_active_count", 256'(active_count), 256'd0);

      // single passenger: e=1 start=2 dest=2 (becomes 3), x0=300, xexit=100
      sim_state = 2'd1;
      rand_bits = mk_rand(1, 2, 2, 300, 10);
      spawn_en  = 1'b1;
      sb_push("spawn_state", 256'd1);
      sb_push("spawn_x", 256'd300);
      sb_push("spawn_floor", 256'd2);
      sb_push("spawn_elev", 256'd1);
      step();
      spawn_en = 1'b0; rand_bits = '0;
      sb_pop(256'(st(0)));
      sb_pop(256'(p_xpos[9:0]));
      sb_pop(256'(p_floor[2:0]));
      sb_pop(256'(p_elev[0]));
      sb_push("walk_in_state", 256'd2);
      sb_push("active_count_lag", 256'd1);
      step();
      sb_pop(256'(st(0)));
      sb_pop(256'(active_count));
      repeat (13) tick_pulse();
      check_eq("walk13_x", 256'(p_xpos[9:0]), 256'd261);
      check_eq("walk13_state", 256'(st(0)), 256'd2);
      sb_push("walk14_state", 256'd3);
      sb_push("walk14_x", 256'd260);
      sb_push("wait_floor_req", 256'd1 << 8);
      tick_pulse();
      sb_pop(256'(st(0)));
      sb_pop(256'(p_xpos[9:0]));
      sb_pop(256'(floor_req));

      // board car1 at floor 2, ride to floor 3
      elev_floor = {3'd2, 3'd0}; elev_door_open = 2'b10;
      sb_push("board_state", 256'd4);
      sb_push("ride_car_req", 256'd1 << 9);
      sb_push("ride_floor_req", 256'd0);
      step();
      sb_pop(256'(st(0)));
      sb_pop(256'(car_req));
      sb_pop(256'(floor_req));
      elev_floor = {3'd3, 3'd0};
      sb_push("exit_state", 256'd5);
      sb_push("exit_floor", 256'd3);
      step();
      sb_pop(256'(st(0)));
      sb_pop(256'(p_floor[2:0]));
      elev_door_open = 2'b00;
      sb_push("walk_out_ticks", 256'd54);
      sb_push("walk_out_x", 256'd100);
      sb_push("delivered_1", 256'd1);
      n = 0;
      while (n < 100) begin
         tick = 1'b1; step(); tick = 1'b0; n++;
         if (st(0) == 3'd0) break;
         step();
      end
      sb_pop(256'(n));
      sb_pop(256'(p_xpos[9:0]));
      sb_pop(256'(delivered_count));
      step();
      check_eq("active_count_idle", 256'(active_count), 256'd0);

      // six passengers waiting for car0 at floor 0
      rand_bits = mk_rand(0, 0, 1, 220, 10);
      spawn_en = 1'b1;
      repeat (6) step();
      spawn_en = 1'b0;
      step();
      tick_pulse();
      check_eq("six_wait", 256'(p_state[17:0]), 256'({6{3'd3}}));
      check_eq("six_floor_req", 256'(floor_req), 256'd1);

      // out-of-range start floor rejected
      rand_bits = mk_rand(0, 7, 1, 100, 10);
      spawn_en = 1'b1;
      step();
      spawn_en = 1'b0;
      step();
      check_eq("reject_start7", 256'(active_mask), 256'h3F);

      // capacity: one boarding per cycle, four max
      elev_door_open = 2'b01;
      for (int k = 0; k < 4; k++) begin
         sb_push($sformatf("board_slot%0d", k), 256'd4);
         sb_push($sformatf("wait_slot%0d", k + 1), 256'd3);
         step();
         sb_pop(256'(st(k)));
         sb_pop(256'(st(k + 1)));
      end
      step(); step();
      check_eq("cap_slot4", 256'(st(4)), 256'd3);
      check_eq("cap_slot5", 256'(st(5)), 256'd3);
      check_eq("cap_floor_req", 256'(floor_req), 256'd1);
      check_eq("cap_car_req", 256'(car_req), 256'd2);

      // fill to MAX_ACTIVE at car1 floor 5 (dest 5 wraps to 0)
      rand_bits = mk_rand(1, 5, 5, 260, 10);
      spawn_en = 1'b1;
      repeat (6) step();
      spawn_en = 1'b0;
      step();
      check_eq("full_count", 256'(active_count), 256'd12);
      spawn_en = 1'b1;
      step();
      spawn_en = 1'b0;
      step();
      check_eq("reject_max_active", 256'(active_mask), 256'hFFF);
      tick_pulse();
      check_eq("two_hall_calls", 256'(floor_req), 256'h801);
      elev_floor = {3'd5, 3'd0}; elev_door_open = 2'b11;
      sb_push("wrap_car_req", 256'h42);
      sb_push("car1_board", 256'd4);
      step();
      sim_state = 2'd2;
      sb_pop(256'(car_req));
      sb_pop(256'(st(6)));

      // pause freezes everything
      repeat (5) tick_pulse();
      exp_st = '0; exp_x = '0;
      for (int i = 0; i < 12; i++) begin
         exp_st[i*3 +: 3] = (i < 4 || i == 6) ? 3'd4 : 3'd3;
         exp_x[i*10 +: 10] = (i < 6) ? 10'd220 : 10'd260;
      end
      check_eq("pause_state", 256'(p_state), 256'(exp_st));
      check_eq("pause_xpos", 256'(p_xpos), 256'(exp_x));
      check_eq("pause_count", 256'(active_count), 256'd12);

      // ending clears slots, keeps the trip counter
      sim_state = 2'd3;
      step();
      check_eq("end_state", 256'(p_state), 256'd0);
      check_eq("end_xpos", 256'(p_xpos), 256'd0);
      check_eq("end_floor_req", 256'(floor_req), 256'd0);
      check_eq("end_car_req", 256'(car_req), 256'd0);
      check_eq("end_delivered", 256'(delivered_count), 256'd1);
      sim_state = 2'd0;
      step();
      check_eq("start_delivered", 256'(delivered_count), 256'd0);
      check_eq("start_active_count", 256'(active_count), 256'd0);
      check_eq("sb_drained", 256'(sb_q.size()), 256'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
